// File: rtl/axi_lite_load_ram_if.sv
// AXI4-Lite slave bus bundle for axi_lite_load_ram; the master modport drives requests.
interface axi_lite_load_ram_if #(
    parameter int DATA_W = 32
) ();
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [31:0]           axi_awaddr;
    logic [2:0]            axi_awprot;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [DATA_W-1:0]     axi_wdata;
    logic [DATA_W/8-1:0]   axi_wstrb;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [1:0]            axi_bresp;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [31:0]           axi_araddr;
    logic [2:0]            axi_arprot;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [DATA_W-1:0]     axi_rdata;
    logic [1:0]            axi_rresp;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awprot,
        output axi_wvalid, axi_wdata, axi_wstrb,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arprot,
        output axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awprot,
        input  axi_wvalid, axi_wdata, axi_wstrb,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arprot,
        input  axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp
    );
endinterface

// File: rtl/axi_lite_load_ram.sv
// AXI4-Lite RAM with a streaming loader port that holds the core in reset while it fills the RAM.
module axi_lite_load_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4096,
    parameter     INIT_FILE  = "",
    parameter int LOAD_WORDS = DEPTH,
    parameter int BOOT_LOAD  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_lite_load_ram_if.slave            axi,
    input  logic                          load_start,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DATA_W-1:0]             load_data,
    output logic                          load_busy,
    output logic                          rst_core,
    output logic [$clog2(LOAD_WORDS):0]   load_count
);
    localparam int BW  = DATA_W / 8;
    localparam int OFF = $clog2(BW);
    localparam int AWI = $clog2(DEPTH);
    localparam int CW  = $clog2(LOAD_WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(LOAD_WORDS - 1);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    function automatic logic [AWI-1:0] word_idx(input logic [31:0] a);
        return a[OFF +: AWI];
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        return (a >> (OFF + AWI)) != 32'd0;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              aw_full_q, aw_full_d;
    logic              w_full_q, w_full_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic [AWI-1:0]    aw_idx_q, ar_idx_q;
    logic              aw_oor_q, ar_oor_q;
    logic [DATA_W-1:0] w_data_q;
    logic [BW-1:0]     w_strb_q;

    logic aw_hs, w_hs, ar_hs, wr_go, rd_go, ld_fire, busy;
    logic [31:0]    ld_wide;
    logic [AWI-1:0] ld_idx;

    assign busy    = (state_q == S_LOAD);
    assign ld_fire = load_valid && busy;
    assign ld_wide = 32'(cnt_q);
    assign ld_idx  = ld_wide[AWI-1:0];

    assign axi.axi_awready = !aw_full_q && !busy;
    assign axi.axi_wready  = !w_full_q && !busy;
    assign axi.axi_arready = !rd_pend_q && !rvalid_q && !busy;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bresp   = bresp_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;

    assign aw_hs = axi.axi_awvalid && axi.axi_awready;
    assign w_hs  = axi.axi_wvalid && axi.axi_wready;
    assign ar_hs = axi.axi_arvalid && axi.axi_arready;
    // Single AXI RAM port: a ready write always wins and the read waits a cycle.
    assign wr_go = aw_full_q && w_full_q && !bvalid_q;
    assign rd_go = rd_pend_q && !wr_go;

    assign load_ready = busy;
    assign load_busy  = busy;
    assign rst_core   = busy;
    assign load_count = cnt_q;

    logic unused_bits;
    assign unused_bits = ^{axi.axi_awprot, axi.axi_arprot, ld_wide};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rd_pend_d = rd_pend_q;
        rvalid_d  = rvalid_q;

        case (state_q)
            S_IDLE: if (load_start) begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            S_LOAD: if (ld_fire) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (aw_hs) aw_full_d = 1'b1;
        if (w_hs)  w_full_d  = 1'b1;
        if (wr_go) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_oor_q ? SLVERR : OKAY;
        end else if (bvalid_q && axi.axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) rd_pend_d = 1'b1;
        if (rd_go) begin
            rd_pend_d = 1'b0;
            rvalid_d  = 1'b1;
        end else if (rvalid_q && axi.axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= (BOOT_LOAD != 0) ? S_LOAD : S_IDLE;
            cnt_q     <= '0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rd_pend_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rd_pend_q <= rd_pend_d;
            rvalid_q  <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_idx_q <= word_idx(axi.axi_awaddr);
            aw_oor_q <= out_of_range(axi.axi_awaddr);
        end
        if (w_hs) begin
            w_data_q <= axi.axi_wdata;
            w_strb_q <= axi.axi_wstrb;
        end
        if (ar_hs) begin
            ar_idx_q <= word_idx(axi.axi_araddr);
            ar_oor_q <= out_of_range(axi.axi_araddr);
        end
    end

    // Port A serves AXI byte-lane writes, port B the loader; reset freezes both.
    always_ff @(posedge clk) begin
        if (rst && wr_go && !aw_oor_q) begin
            for (int b = 0; b < BW; b++) begin
                if (w_strb_q[b]) mem[aw_idx_q][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
        end
        if (rst && ld_fire) mem[ld_idx] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (rd_go) begin
            rdata_q <= ar_oor_q ? '0 : mem[ar_idx_q];
            rresp_q <= ar_oor_q ? SLVERR : OKAY;
        end
    end
endmodule

// File: tb/tb_axi_lite_load_ram.sv
// Scoreboard bench for axi_lite_load_ram: boot load, AXI writes/reads, errors and loader restart.
module tb_axi_lite_load_ram;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4096;
    localparam int LOAD_WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_lite_load_ram_if #(.DATA_W(DATA_W)) bus ();

    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data  = '0;
    logic        load_busy;
    logic        rst_core;
    logic [2:0]  load_count;

    axi_lite_load_ram #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_FILE(""),
        .LOAD_WORDS(LOAD_WORDS), .BOOT_LOAD(1)
    ) dut (
        .clk(clk), .rst(rst), .axi(bus),
        .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_busy(load_busy), .rst_core(rst_core),
        .load_count(load_count)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [DEPTH];
    logic [33:0] r_q [$];
    logic [1:0]  b_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic void mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a[13:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic [33:0] mdl_rd(input logic [31:0] a);
        if (!in_range(a)) return {2'b10, 32'h0};
        return {2'b00, mdl[a[13:2]]};
    endfunction

    function automatic logic [1:0] mdl_bresp(input logic [31:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic pop_r(input string tag);
        logic [33:0] e;
        if (r_q.size() == 0) begin
            check({tag, "_r_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = r_q.pop_front();
            check({tag, "_rdata"}, 64'(bus.axi_rdata), 64'(e[31:0]));
            check({tag, "_rresp"}, 64'(bus.axi_rresp), 64'(e[33:32]));
        end
    endtask

    task automatic pop_b(input string tag);
        logic [1:0] e;
        if (b_q.size() == 0) begin
            check({tag, "_b_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = b_q.pop_front();
            check({tag, "_bresp"}, 64'(bus.axi_bresp), 64'(e));
        end
    endtask

    task automatic drain(input string tag, input int nb, input int nr);
        int budget = 40;
        bus.axi_bready = 1'b1;
        bus.axi_rready = 1'b1;
        while ((nb > 0 || nr > 0) && budget > 0) begin
            if (bus.axi_bvalid && nb > 0) begin pop_b(tag); nb--; end
            if (bus.axi_rvalid && nr > 0) begin pop_r(tag); nr--; end
            tick();
            budget--;
        end
        if (nb > 0 || nr > 0) check({tag, "_resp_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0, a_rdy, w_rdy;
        int budget = 40;
        bus.axi_awaddr = a; bus.axi_wdata = d; bus.axi_wstrb = s;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
        while (!(aw_done && w_done) && budget > 0) begin
            a_rdy = bus.axi_awready && !aw_done;
            w_rdy = bus.axi_wready && !w_done;
            tick();
            if (a_rdy) begin aw_done = 1; bus.axi_awvalid = 1'b0; end
            if (w_rdy) begin w_done = 1; bus.axi_wvalid = 1'b0; end
            budget--;
        end
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        if (!(aw_done && w_done)) check({tag, "_aw_w_timeout"}, 64'd0, 64'd1);
        else begin
            b_q.push_back(mdl_bresp(a));
            mdl_wr(a, d, s);
        end
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a);
        int budget = 40;
        bus.axi_araddr = a;
        bus.axi_arvalid = 1'b1;
        while (!bus.axi_arready && budget > 0) begin tick(); budget--; end
        if (budget == 0) check({tag, "_ar_timeout"}, 64'd0, 64'd1);
        else begin
            tick();
            r_q.push_back(mdl_rd(a));
        end
        bus.axi_arvalid = 1'b0;
    endtask

    logic [33:0] e27;

    initial begin
        bus.axi_awvalid = 0; bus.axi_awaddr = 0; bus.axi_awprot = 0;
        bus.axi_wvalid = 0; bus.axi_wdata = 0; bus.axi_wstrb = 0;
        bus.axi_bready = 0; bus.axi_arvalid = 0; bus.axi_araddr = 0;
        bus.axi_arprot = 0; bus.axi_rready = 0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        rst = 1'b0;
        tick(); tick(); tick();
        check("rst_bvalid", 64'(bus.axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(bus.axi_rvalid), 64'd0);
        check("rst_rdata", 64'(bus.axi_rdata), 64'd0);
        check("rst_count", 64'(load_count), 64'd0);
        rst = 1'b1;
        check("boot_rst_core", 64'(rst_core), 64'd1);
        check("boot_awready", 64'(bus.axi_awready), 64'd0);
        check("boot_arready", 64'(bus.axi_arready), 64'd0);
        check("boot_load_ready", 64'(load_ready), 64'd1);

        // Boot session of four words
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'(i + 1) * 32'h11;
            if (i == 3) check("boot_busy_before_last", 64'(rst_core), 64'd1);
            tick();
            mdl[i] = 32'(i + 1) * 32'h11;
        end
        load_valid = 1'b0;
        check("boot_rst_core_fall", 64'(rst_core), 64'd0);
        check("boot_count", 64'(load_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            axi_read("boot_rd", 32'(i * 4));
            drain("boot_rd", 0, 1);
        end

        // Early W with partial strobes, late AW
        axi_write("pre", 32'h10, 32'h11223344, 4'hF);
        drain("pre", 1, 0);
        bus.axi_bready = 1'b0;
        bus.axi_wdata = 32'hAABBCCDD; bus.axi_wstrb = 4'b0101; bus.axi_wvalid = 1'b1;
        check("early_wready", 64'(bus.axi_wready), 64'd1);
        tick();
        bus.axi_wvalid = 1'b0;
        tick(); tick();
        bus.axi_awaddr = 32'h10; bus.axi_awvalid = 1'b1;
        check("late_awready", 64'(bus.axi_awready), 64'd1);
        tick();
        bus.axi_awvalid = 1'b0;
        b_q.push_back(mdl_bresp(32'h10));
        mdl_wr(32'h10, 32'hAABBCCDD, 4'b0101);
        tick();
        check("b_latency", 64'(bus.axi_bvalid), 64'd1);
        drain("strb_b", 1, 0);
        axi_read("strb_rd", 32'h10);
        drain("strb_rd", 0, 1);

        // Read held with rready low
        axi_write("w20", 32'h20, 32'hCAFEF00D, 4'hF);
        drain("w20", 1, 0);
        bus.axi_rready = 1'b0;
        bus.axi_araddr = 32'h20; bus.axi_arvalid = 1'b1;
        check("r27_arready", 64'(bus.axi_arready), 64'd1);
        tick();
        bus.axi_arvalid = 1'b0;
        e27 = mdl_rd(32'h20);
        r_q.push_back(e27);
        check("r27_arready_n1", 64'(bus.axi_arready), 64'd0);
        check("r27_rvalid_n1", 64'(bus.axi_rvalid), 64'd0);
        tick();
        check("r27_rvalid_n2", 64'(bus.axi_rvalid), 64'd1);
        pop_r("r27");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("r27_hold_rvalid", 64'(bus.axi_rvalid), 64'd1);
            check("r27_hold_rdata", 64'(bus.axi_rdata), 64'(e27[31:0]));
            check("r27_hold_arready", 64'(bus.axi_arready), 64'd0);
        end
        bus.axi_rready = 1'b1;
        tick();
        check("r27_rvalid_done", 64'(bus.axi_rvalid), 64'd0);
        check("r27_arready_back", 64'(bus.axi_arready), 64'd1);

        // Same-cycle write and read of one address
        bus.axi_awaddr = 32'h40; bus.axi_araddr = 32'h40;
        bus.axi_wdata = 32'h5A5A1234; bus.axi_wstrb = 4'hF;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_arvalid = 1'b1;
        check("coll_ready", 64'({bus.axi_awready, bus.axi_wready, bus.axi_arready}), 64'd7);
        tick();
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
        b_q.push_back(mdl_bresp(32'h40));
        mdl_wr(32'h40, 32'h5A5A1234, 4'hF);
        r_q.push_back(mdl_rd(32'h40));
        drain("coll", 1, 1);

        // Out-of-range accesses
        axi_write("oor_w", 32'h4000, 32'hFFFFFFFF, 4'hF);
        drain("oor_w", 1, 0);
        axi_read("oor_r", 32'h4000);
        drain("oor_r", 0, 1);
        axi_read("oor_alias", 32'h0);
        drain("oor_alias", 0, 1);

        // Outstanding read survives a load_start; new handshakes blocked
        bus.axi_rready = 1'b0;
        bus.axi_araddr = 32'h8; bus.axi_arvalid = 1'b1; load_start = 1'b1;
        check("ls_arready", 64'(bus.axi_arready), 64'd1);
        tick();
        bus.axi_arvalid = 1'b0; load_start = 1'b0;
        r_q.push_back(mdl_rd(32'h8));
        check("ls_busy", 64'(load_busy), 64'd1);
        check("ls_count0", 64'(load_count), 64'd0);
        check("ls_awready", 64'(bus.axi_awready), 64'd0);
        drain("ls_rd", 0, 1);
        check("ls_arready_blk", 64'(bus.axi_arready), 64'd0);

        // Reset in the middle of a session
        load_valid = 1'b1;
        load_data = 32'hA0; tick();
        load_data = 32'hA1; tick();
        load_valid = 1'b0;
        mdl[0] = 32'hA0; mdl[1] = 32'hA1;
        check("mid_count2", 64'(load_count), 64'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_count", 64'(load_count), 64'd0);
        check("mid_rst_busy", 64'(load_busy), 64'd1);
        check("keep_w0", 64'(dut.mem[0]), 64'(mdl[0]));
        check("keep_w1", 64'(dut.mem[1]), 64'(mdl[1]));
        check("keep_w2", 64'(dut.mem[2]), 64'(mdl[2]));
        load_valid = 1'b1;
        load_data = 32'hC0; tick();
        load_data = 32'hC1; load_start = 1'b1; tick();
        load_start = 1'b0;
        check("start_ignored", 64'(load_count), 64'd2);
        load_data = 32'hC2; tick();
        load_data = 32'hC3; tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'hC0 + 32'(i);
        check("restart_busy", 64'(load_busy), 64'd0);
        check("restart_count", 64'(load_count), 64'd4);
        axi_read("restart_rd1", 32'h4);
        drain("restart_rd1", 0, 1);
        axi_read("restart_rd3", 32'hC);
        drain("restart_rd3", 0, 1);

        check("sb_r_empty", 64'(r_q.size()), 64'd0);
        check("sb_b_empty", 64'(b_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_load_ram.md
AXI_LITE_LOAD_RAM -- requirements
Module: axi_lite_load_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI/RAM data width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4096, RAM depth in words; power of two.
REQ-003 SHALL have parameter INIT_FILE, default "", hex initialisation file; empty means RAM powers up as zero.
REQ-004 SHALL have parameter LOAD_WORDS, default DEPTH, words per loader session; 1..DEPTH.
REQ-005 SHALL have parameter BOOT_LOAD, default 1; when 1, the loader session starts automatically at reset release.
REQ-006 SHALL have one clock and a synchronous, active-low reset:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  synchronous reset, active-low
REQ-007 SHALL have the AXI4-Lite slave ports (A = 32):
  axi_awvalid/axi_awready  in/out  1  write-address handshake; axi_awaddr in A; axi_awprot in 3 (ignored)
  axi_wvalid/axi_wready  in/out  1  write-data handshake; axi_wdata in DATA_W; axi_wstrb in DATA_W/8
  axi_bvalid/axi_bready  out/in  1  write response; axi_bresp out 2
  axi_arvalid/axi_arready  in/out  1  read-address handshake; axi_araddr in A; axi_arprot in 3 (ignored)
  axi_rvalid/axi_rready  out/in  1  read response; axi_rdata out DATA_W; axi_rresp out 2
REQ-008 SHALL have the loader ports:
  load_start  in  1  pulse; starts a session from IDLE
  load_valid/load_ready  in/out  1  load-word handshake
  load_data  in  DATA_W  word to store
  load_busy  out  1  high while a session is active
  rst_core  out  1  core hold-in-reset, equal to load_busy
  load_count  out  clog2(LOAD_WORDS)+1  words stored in current/last session

Function
REQ-009 SHALL decode word index = axi_*addr[clog2(DATA_W/8) +: clog2(DEPTH)]; lower byte-offset bits SHALL be ignored.
REQ-010 SHALL treat any address >= DEPTH*DATA_W/8 as out of range: a write SHALL NOT modify RAM and SHALL return bresp=2'b10 (SLVERR); a read SHALL return rresp=2'b10 with rdata=0; in-range accesses SHALL return 2'b00.
REQ-011 SHALL capture AW and W independently, each into a one-entry holding register; awready = !aw_full && !load_busy; wready = !w_full && !load_busy.
REQ-012 SHALL perform the RAM write in the first cycle in which both holding registers are full and bvalid=0; only bytes with wstrb=1 SHALL change; both holding registers SHALL clear in that cycle.
REQ-013 SHALL assert bvalid the cycle after the write cycle and hold it, with bresp stable, until bvalid&&bready.
REQ-014 SHALL assert arready = !rd_pending && !axi_rvalid && !load_busy.
REQ-015 SHALL produce read latency 2: AR handshake at cycle N, RAM access at N+1, rvalid=1 with registered rdata at N+2; rdata/rresp SHALL be stable while rvalid && !rready.
REQ-016 SHALL give the AXI side a single RAM port: when a pending write and a pending read access coincide, the write SHALL go first and the read access SHALL slip one cycle.
REQ-017 SHALL implement loader FSM states IDLE and LOAD: IDLE->LOAD on load_start (counter <= 0); LOAD->IDLE in the cycle the LOAD_WORDS-th word is accepted; load_start in LOAD SHALL be ignored.
REQ-018 SHALL, in LOAD, drive load_ready=1 and write load_data to word address load_count on each load_valid&&load_ready, then increment load_count.
REQ-019 SHALL drive load_busy = rst_core = (state==LOAD); load_count SHALL hold its final value in IDLE until the next load_start.
REQ-020 SHALL NOT abort an AXI transaction already accepted when LOAD begins: an outstanding B or R response SHALL still be delivered; new AXI handshakes SHALL be blocked until IDLE.
REQ-021 SHALL write loader data through a second RAM port, independent of the AXI port.

Reset
REQ-022 SHALL, with rst=0 at a rising edge, clear holding registers, rd_pending, bvalid, rvalid, rdata, bresp, rresp and load_count; RAM contents SHALL be preserved.
REQ-023 SHALL enter LOAD (rst_core=1) after reset when BOOT_LOAD=1; otherwise IDLE (rst_core=0).
REQ-024 SHALL, on reset mid-session, discard the session and restart per REQ-023; RAM words already written SHALL remain.

Verification
REQ-025 BOOT_LOAD=1, LOAD_WORDS=4, stream 0x11,0x22,0x33,0x44 -> rst_core falls the cycle after the 4th word is accepted; load_count=4; AXI reads of 0x0,0x4,0x8,0xC return those words.
REQ-026 W (0xAABBCCDD, wstrb=4'b0101) 3 cycles before AW (0x10) over 0x11223344 -> bvalid 1 cycle after AW handshake, bresp=0; readback 0x11BB33DD.
REQ-027 AR 0x20 with rready held 0 for 5 cycles -> rvalid at N+2, rdata stable, arready=0 until the rvalid&&rready handshake.
REQ-028 Write to 0x40 and read of 0x40 presented in the same cycle -> read returns the new data.
REQ-029 Write to 0x4000 (DEPTH=4096) -> bresp=2'b10, RAM unchanged; read 0x4000 -> rresp=2'b10, rdata=0.
REQ-030 Pulse rst low at word 2 of a session -> load_count=0, session restarts, words 0..1 retained.
